// File: rtl/divisibility_checker.sv
// Serial divisibility tester: computes num mod DIVISOR one operand bit per
// clock, MSB first, and reports remainder, divisible flag, a done pulse and
// a saturating count of divisible results.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; results hold the last completed test
//   S_SHIFT | folding one operand bit per cycle into the residue
//   S_DONE  | publishing residue to outputs, pulsing done, back to idle
module divisibility_checker #(
  parameter  int WIDTH   = 8,
  parameter  int DIVISOR = 3,
  localparam int RW      = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    remainder,
  output logic             isDivisible,
  output logic [15:0]      divCount
);

  // Index width kept at least one bit so WIDTH = 1 still has a legal vector.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Modulus at residue-step width; 2r + bit always fits in RW+1 bits.
  localparam logic [RW:0] DIV_W = (RW + 1)'(DIVISOR);

  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [RW-1:0]    res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic             isdiv_q, isdiv_d;
  logic [15:0]      div_cnt_q, div_cnt_d;

  logic             cur_bit;
  logic [RW:0]      res_dbl;
  logic [RW:0]      res_red;
  logic [RW-1:0]    res_step;

  // One residue step: r' = 2r + bit, reduced by a single conditional subtract.
  always_comb begin
    cur_bit  = opnd_q[idx_q];
    res_dbl  = {res_q, cur_bit};
    res_red  = (res_dbl >= DIV_W) ? (res_dbl - DIV_W) : res_dbl;
    res_step = RW'(res_red);
  end

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    idx_d     = idx_q;
    res_d     = res_q;
    done_d    = 1'b0;
    rem_d     = rem_q;
    isdiv_d   = isdiv_q;
    div_cnt_d = div_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opnd_d  = num;
          res_d   = '0;
          idx_d   = IDX_MSB;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        res_d = res_step;
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      S_DONE: begin
        rem_d   = res_q;
        isdiv_d = (res_q == '0);
        if ((res_q == '0) && (div_cnt_q != 16'hFFFF)) begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy is registered from the next state so it tracks SHIFT/DONE exactly.
    busy_d = (state_d != S_IDLE);
  end

  // State and result registers; reset aborts any test in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opnd_q    <= '0;
      idx_q     <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rem_q     <= '0;
      isdiv_q   <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      opnd_q    <= opnd_d;
      idx_q     <= idx_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rem_q     <= rem_d;
      isdiv_q   <= isdiv_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign remainder   = rem_q;
  assign isDivisible = isdiv_q;
  assign divCount    = div_cnt_q;

endmodule

// File: tb/tb_divisibility_checker.sv
// Bench for divisibility_checker: two instances (DIVISOR 3 and 2) driven in
// lockstep and compared against a plain-arithmetic reference model.
module tb_divisibility_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] num;

  logic        busy3, done3, div3;
  logic [1:0]  rem3;
  logic [15:0] cnt3;
  logic        busy2, done2, div2;
  logic [0:0]  rem2;
  logic [15:0] cnt2;

  int vectors;
  int miscompares;

  // Reference model state: results of the last completed test.
  int exp_rem3, exp_div3, exp_cnt3;
  int exp_rem2, exp_div2, exp_cnt2;

  divisibility_checker #(.WIDTH(8), .DIVISOR(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .num(num),
    .busy(busy3), .done(done3), .remainder(rem3),
    .isDivisible(div3), .divCount(cnt3)
  );

  divisibility_checker #(.WIDTH(8), .DIVISOR(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .num(num),
    .busy(busy2), .done(done2), .remainder(rem2),
    .isDivisible(div2), .divCount(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_results();
    check("rem3", 32'(rem3), 32'(exp_rem3));
    check("div3", 32'(div3), 32'(exp_div3));
    check("cnt3", 32'(cnt3), 32'(exp_cnt3));
    check("rem2", 32'(rem2), 32'(exp_rem2));
    check("div2", 32'(div2), 32'(exp_div2));
    check("cnt2", 32'(cnt2), 32'(exp_cnt2));
  endtask

  task automatic model_reset();
    exp_rem3 = 0; exp_div3 = 0; exp_cnt3 = 0;
    exp_rem2 = 0; exp_div2 = 0; exp_cnt2 = 0;
  endtask

  task automatic model_complete(input logic [7:0] n);
    exp_rem3 = int'(n) % 3;
    exp_div3 = (exp_rem3 == 0) ? 1 : 0;
    if (exp_div3 == 1 && exp_cnt3 < 65535) exp_cnt3++;
    exp_rem2 = int'(n) % 2;
    exp_div2 = (exp_rem2 == 0) ? 1 : 0;
    if (exp_div2 == 1 && exp_cnt2 < 65535) exp_cnt2++;
  endtask

  // Drive inputs for the next edge while a test is in flight.
  task automatic drive_busy(input logic [7:0] n, input bit hold, input bit noise);
    if (hold) start = 1'b1;
    else      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    num = noise ? 8'($urandom) : n;
  endtask

  // One test: start accepted on the next edge, done expected exactly 9 edges later.
  task automatic run_test(input logic [7:0] n, input bit hold, input bit noise);
    @(negedge clk);
    start = 1'b1;
    num   = n;
    @(posedge clk);
    #1;
    drive_busy(n, hold, noise);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      if (c < 9) begin
        check("done_low3", 32'(done3), 32'd0);
        check("done_low2", 32'(done2), 32'd0);
        check("busy3", 32'(busy3), 32'd1);
        check("busy2", 32'(busy2), 32'd1);
        if (c == 1 || c == 8) check_results();
        drive_busy(n, hold, noise);
      end else begin
        model_complete(n);
        check("done3", 32'(done3), 32'd1);
        check("done2", 32'(done2), 32'd1);
        check("idle3", 32'(busy3), 32'd0);
        check("idle2", 32'(busy2), 32'd0);
        check_results();
        start = hold;
        num   = n;
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy3", 32'(busy3), 32'd0);
    check("rst_done3", 32'(done3), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_done2", 32'(done2), 32'd0);
    check_results();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst_n = 1'b0;
    start = 1'b0;
    num   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_outputs();
    end

    // Directed operands.
    run_test(8'd45,  1'b0, 1'b0);
    run_test(8'd100, 1'b0, 1'b0);
    run_test(8'd255, 1'b0, 1'b0);
    run_test(8'd0,   1'b0, 1'b0);
    run_test(8'd7,   1'b0, 1'b0);
    run_test(8'd6,   1'b0, 1'b0);

    // start held high with num wiggling while busy: one done per 10 cycles.
    for (int i = 0; i < 3; i++) run_test(8'd45, 1'b1, 1'b1);
    run_test(8'd45, 1'b0, 1'b1);

    // Random operands, including noise on start/num during busy.
    for (int i = 0; i < 40; i++) run_test(8'($urandom), 1'b0, 1'b1);

    // Reset in the middle of a test.
    @(negedge clk);
    start = 1'b1;
    num   = 8'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_outputs();
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("abort_done3", 32'(done3), 32'd0);
      check("abort_done2", 32'(done2), 32'd0);
    end
    run_test(8'd100, 1'b0, 1'b0);

    // Saturation of the divisible counter.
    @(negedge clk);
    force u_dut3.div_cnt_q = 16'hFFFE;
    force u_dut2.div_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release u_dut3.div_cnt_q;
    release u_dut2.div_cnt_q;
    exp_cnt3 = 65534;
    exp_cnt2 = 65534;
    @(posedge clk);
    #1;
    check("held_cnt3", 32'(cnt3), 32'(exp_cnt3));
    check("held_cnt2", 32'(cnt2), 32'(exp_cnt2));
    run_test(8'd0,  1'b0, 1'b0);
    run_test(8'd6,  1'b0, 1'b0);
    run_test(8'd12, 1'b0, 1'b1);
    check("sat_cnt3", 32'(cnt3), 32'hFFFF);
    check("sat_cnt2", 32'(cnt2), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divisibility_checker.md
# divisibility_checker

Parametrised serial divisibility tester that generalises the single-bit even/odd check. It accepts a WIDTH-bit operand on a start strobe and computes the operand modulo DIVISOR bit-serially, MSB first, one bit per clock. On completion it reports the remainder, a divisible flag and a one-cycle done pulse. It sits on the arithmetic-test datapath wherever a multi-bit divisibility or parity decision is needed without a full divider.

## Interface
- WIDTH, 8: operand width in bits; ≥ 1.
- DIVISOR, 3: constant modulus; ≥ 2. DIVISOR = 2 reproduces the even/odd test.
- RW (localparam), $clog2(DIVISOR): remainder width.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to test num; honoured only in IDLE.
- num  input  WIDTH  operand; sampled on the cycle start is accepted.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; results valid and updated.
- remainder  output  RW  num mod DIVISOR of the last completed test.
- isDivisible  output  1  1 when the last remainder == 0.
- divCount  output  16  saturating count of completed tests with isDivisible = 1.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: busy = 0. If start = 1: latch num into a shift register, clear the working residue to 0, load the bit index with WIDTH-1, and go to SHIFT. If start = 0, stay in IDLE.
- SHIFT: each cycle, take bit = operand[index] and update the residue as r' = 2r + bit. If r' ≥ DIVISOR, subtract DIVISOR once. Compute r' at RW+1 bits; it is always < 2·DIVISOR, so no wider intermediate is needed. When index == 0, that cycle's update is the final one; go to DONE. Otherwise decrement index.
- DONE: copy the final residue to remainder and set isDivisible = (residue == 0). Increment divCount if divisible, holding at 16'hFFFF. Assert done for this single cycle, then return to IDLE.
- remainder, isDivisible and divCount hold their values between tests. They change only on the DONE cycle.
- start while busy = 1, including the DONE cycle, is ignored and not queued. num changes after acceptance have no effect.
- Asserting rst_n low at any time, including mid-SHIFT, aborts the test at once. The block returns to IDLE with no done pulse for the aborted operand.

## Timing
- Reset values: busy = 0, done = 0, remainder = 0, isDivisible = 0, divCount = 0, FSM = IDLE, internal registers = 0.
- start accepted on edge 0 → SHIFT occupies edges 1..WIDTH → DONE state on edge WIDTH+1. done and the new results are visible after edge WIDTH+1.
- Latency from accepted start to done is WIDTH+1 cycles. The earliest next accepted start is one cycle after done, so throughput is one test per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- WIDTH = 1: SHIFT lasts exactly one cycle and the result is num[0] mod DIVISOR.

## Test plan
- WIDTH=8, DIVISOR=3, num=8'd45, start pulsed at cycle 0 → done high in cycle 9 only; remainder=0, isDivisible=1, divCount=1.
- WIDTH=8, DIVISOR=3, num=8'd100 → remainder=1, isDivisible=0, divCount unchanged. Then num=8'd255 → remainder=0, isDivisible=1. Then num=8'd0 → remainder=0, isDivisible=1.
- WIDTH=8, DIVISOR=2, num=8'd7 then 8'd6 → remainder=1/isDivisible=0, then remainder=0/isDivisible=1 (even/odd equivalence).
- Start held high continuously with num=8'd45 → one done every 10 cycles; changing num or re-pulsing start during busy has no effect on the in-flight result.
- rst_n driven low at cycle 4 of a test, released, then a new test started with num=8'd100 → no done for the aborted test; all outputs read reset values; the new test completes normally with remainder=1.
- Force divCount to 16'hFFFF (or run 65535 divisible tests), then one more divisible test → divCount stays 16'hFFFF.
